if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset (word aligned).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on rising clk.
REQ-004 The block SHALL have port stall, input, 1 bit: the IF/ID register holds its contents this cycle.
REQ-005 The block SHALL have port redirect, input, 1 bit: a taken branch flushes fetch and reloads the PC.
REQ-006 The block SHALL have port redirect_pc, input, 32 bits: branch target; bits [1:0] ignored and treated as 00.
REQ-007 The block SHALL have port imem_addr, output, 32 bits: byte address to instruction memory, always equal to pc_q.
REQ-008 The block SHALL have port imem_rdata, input, 32 bits: instruction memory word, valid one cycle after its address is presented.
REQ-009 The block SHALL have ports ifid_inst, ifid_pc and ifid_pc4, outputs, 32 bits each: IF/ID instruction, its PC, and its PC+4.
REQ-010 The block SHALL have port ifid_valid, output, 1 bit: IF/ID holds a real instruction; when 0, ifid_inst is a bubble.

Function
REQ-011 The block SHALL hold state pc_q, inflight_q with inflight_pc_q, and a one-entry skid buffer (skid_valid_q, skid_inst_q, skid_pc_q).
REQ-012 arriving = inflight_q; when 1, imem_rdata is the instruction at inflight_pc_q.
REQ-013 The block SHALL compute skid_next_valid = skid_valid_q ? stall : (arriving & stall), forced to 0 on redirect.
REQ-014 The block SHALL set issue = ~redirect & ~skid_next_valid.
REQ-015 When issue = 1, the block SHALL update pc_q <= pc_q+4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), inflight_q <= 1 and inflight_pc_q <= pc_q; when issue = 0 without redirect, it SHALL hold pc_q and clear inflight_q.
REQ-016 When ~stall and no redirect, IF/ID SHALL load the skid entry if skid_valid_q, else the arriving word if arriving, else a bubble (ifid_valid=0, ifid_inst=32'h0000_0000).
REQ-017 When stall and no redirect, IF/ID SHALL hold all four outputs, and an arriving word SHALL be written into the skid buffer if it is empty.
REQ-018 With skid_valid_q=1, the skid buffer SHALL drain into IF/ID on the first cycle with ~stall; no new fetch is issued while the skid buffer is occupied.
REQ-019 Redirect SHALL take priority over stall: pc_q <= {redirect_pc[31:2],2'b00}, inflight_q <= 0, skid_valid_q <= 0, ifid_valid <= 0 and ifid_inst <= 0.
REQ-020 Latency: an instruction issued in cycle n SHALL appear in IF/ID from cycle n+2 if stall is never asserted; steady-state throughput SHALL be one instruction per cycle.
REQ-021 The redirect target SHALL be issued the cycle after redirect and SHALL appear in IF/ID two cycles after redirect, giving a two-bubble penalty.
REQ-022 Under any stall pattern, no instruction SHALL be lost, duplicated or reordered.
REQ-023 ifid_pc4 SHALL equal ifid_pc+4 whenever ifid_valid = 1.

Reset
REQ-024 While rst=1, the block SHALL set pc_q=RESET_PC, inflight_q=0, skid_valid_q=0, ifid_valid=0, ifid_inst=0, ifid_pc=0 and ifid_pc4=0.
REQ-025 Reset SHALL override redirect and stall, and SHALL discard any in-flight or skid instruction.
REQ-026 The first fetch SHALL issue in the first cycle with rst=0.

Configuration
REQ-027 When IF_PERF_CNT_EN is defined, the block SHALL add 32-bit outputs perf_fetch_cnt and perf_stall_cnt, both reset to 0 and wrapping at 2^32.
REQ-028 perf_fetch_cnt SHALL count cycles in which IF/ID loads a valid instruction.
REQ-029 perf_stall_cnt SHALL count cycles with stall=1 and ifid_valid=1.
REQ-030 When IF_PERF_CNT_EN is undefined, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Scenario: RESET_PC=0, memory word at address n = 32'h1000_0000+n, no stall -> ifid_pc = 0, 4, 8... on consecutive cycles starting 2 cycles after reset release, with matching ifid_inst.
REQ-032 Scenario: stall for 3 cycles while ifid_pc=8 -> IF/ID holds pc 8 for 3 cycles, then shows 12, 16 with no gap and no repeat.
REQ-033 Scenario: redirect with redirect_pc=32'h40 while stall=1 and skid full -> next two ifid_valid=0, then ifid_pc=32'h40; the skid instruction never appears.
REQ-034 Scenario: RESET_PC=32'hFFFF_FFF8, no stall -> ifid_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 Scenario: rst asserted for 1 cycle mid-stream with skid full -> all outputs 0 next cycle, and fetch restarts at RESET_PC.
REQ-036 Scenario (IF_PERF_CNT_EN): 10 unstalled cycles followed by 4 stall cycles -> perf_fetch_cnt=10 and perf_stall_cnt=4.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a one-entry skid buffer feeding the
// IF/ID pipeline register. Instruction memory is synchronous: a word arrives
// one cycle after its address is presented on imem_addr.
// Optional feature: define IF_PERF_CNT_EN to add fetch/stall performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  // Fetched instruction together with the address it came from.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_ent_t;

  logic        pc_unused;
  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic        skid_valid_q;
  fetch_ent_t  skid_q;

  logic        arriving;
  logic        skid_next_valid;
  logic        issue;
  logic        load_valid;
  fetch_ent_t  arr_ent;

  assign imem_addr = pc_q;
  assign arriving  = inflight_q;
  assign arr_ent   = '{inst: imem_rdata, pc: inflight_pc_q};
  assign pc_unused = redirect_pc[1] ^ redirect_pc[0];

  // Skid occupancy next cycle decides whether a new fetch may go out; a
  // fetch is never issued while its result would have nowhere to land.
  always_comb begin
    skid_next_valid = 1'b0;
    if (!redirect)
      skid_next_valid = skid_valid_q ? stall : (arriving & stall);
    issue      = ~redirect & ~skid_next_valid;
    load_valid = ~redirect & ~stall & (skid_valid_q | arriving);
  end

  // PC and in-flight tracking; redirect reloads the PC and drops the fetch in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
    end else if (redirect) begin
      pc_q       <= {redirect_pc[31:2], 2'b00};
      inflight_q <= 1'b0;
    end else if (issue) begin
      pc_q          <= pc_q + 32'd4;
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  // Skid buffer: catches the arriving word when IF/ID is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_next_valid;
      if (!redirect && !skid_valid_q && arriving && stall)
        skid_q <= arr_ent;
    end
  end

  // IF/ID register: skid entry has priority over the arriving word to keep order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_inst  <= 32'h0;
      ifid_pc    <= 32'h0;
      ifid_pc4   <= 32'h0;
    end else if (redirect) begin
      ifid_valid <= 1'b0;
      ifid_inst  <= 32'h0;
    end else if (!stall) begin
      if (skid_valid_q) begin
        ifid_valid <= 1'b1;
        ifid_inst  <= skid_q.inst;
        ifid_pc    <= skid_q.pc;
        ifid_pc4   <= skid_q.pc + 32'd4;
      end else if (arriving) begin
        ifid_valid <= 1'b1;
        ifid_inst  <= arr_ent.inst;
        ifid_pc    <= arr_ent.pc;
        ifid_pc4   <= arr_ent.pc + 32'd4;
      end else begin
        ifid_valid <= 1'b0;
        ifid_inst  <= 32'h0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  // Performance counters: valid loads into IF/ID, and stalled cycles holding a real instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (load_valid)          perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall && ifid_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: randomized stall/redirect/reset stimulus against a program-order
// reference model (expected next PC and a memory function), plus directed cases.
module tb_if_stage;
  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] ifid_inst, ifid_pc, ifid_pc4;
  logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  if_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_inst(ifid_inst), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  // Synchronous instruction memory: data one cycle after address.
  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  int n_tests = 0;
  int n_fail  = 0;
  int n_loads = 0;
  int clean   = 0;
  logic [31:0] exp_pc = TB_RESET_PC;
  logic [31:0] hold_inst, hold_pc, hold_pc4;
  logic        hold_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then check the outputs against the model.
  task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic rs);
    stall = s; redirect = r; redirect_pc = rpc; rst = rs;
    @(posedge clk); #1;
    if (rs) begin
      check("rst_valid", {31'b0, ifid_valid}, 32'h0);
      check("rst_inst", ifid_inst, 32'h0);
      check("rst_pc", ifid_pc, 32'h0);
      check("rst_pc4", ifid_pc4, 32'h0);
      exp_pc = TB_RESET_PC;
      clean  = 0;
    end else if (r) begin
      check("redir_valid", {31'b0, ifid_valid}, 32'h0);
      check("redir_inst", ifid_inst, 32'h0);
      exp_pc = {rpc[31:2], 2'b00};
      clean  = 0;
    end else if (s) begin
      check("hold_valid", {31'b0, ifid_valid}, {31'b0, hold_valid});
      check("hold_inst", ifid_inst, hold_inst);
      check("hold_pc", ifid_pc, hold_pc);
      check("hold_pc4", ifid_pc4, hold_pc4);
      clean = 0;
    end else begin
      clean++;
      if (ifid_valid) begin
        check("order_pc", ifid_pc, exp_pc);
        check("order_inst", ifid_inst, mem_word(exp_pc));
        check("order_pc4", ifid_pc4, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        n_loads++;
      end else begin
        check("bubble_inst", ifid_inst, 32'h0);
      end
      if (clean >= 2) check("throughput", {31'b0, ifid_valid}, 32'h1);
    end
    hold_valid = ifid_valid; hold_inst = ifid_inst;
    hold_pc = ifid_pc; hold_pc4 = ifid_pc4;
  endtask

  initial begin
    logic [31:0] pc_before;
    // Reset, then wrap-around fetch from FFFF_FFF8.
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("first_bubble", {31'b0, ifid_valid}, 32'h0);
    step(0, 0, 0, 0);
    check("first_pc", ifid_pc, 32'hFFFF_FFF8);
    step(0, 0, 0, 0);
    check("second_pc", ifid_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    check("wrap_pc", ifid_pc, 32'h0000_0000);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // Three-cycle stall, then no gap and no repeat.
    pc_before = ifid_pc;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("stall_resume_valid", {31'b0, ifid_valid}, 32'h1);
    check("stall_resume_pc", ifid_pc, pc_before + 32'd4);
    step(0, 0, 0, 0);
    check("stall_resume_pc2", ifid_pc, pc_before + 32'd8);

    // Redirect while stalled with the skid full; low target bits ignored.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 32'h0000_0043, 0);
    step(0, 0, 0, 0);
    check("redir_bub2", {31'b0, ifid_valid}, 32'h0);
    step(0, 0, 0, 0);
    check("redir_tgt_valid", {31'b0, ifid_valid}, 32'h1);
    check("redir_tgt_pc", ifid_pc, 32'h0000_0040);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);

    // Reset mid-stream with the skid full.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("restart_pc", ifid_pc, TB_RESET_PC);

`ifdef IF_PERF_CNT_EN
    step(0, 0, 0, 1);
    check("perf_rst_fetch", perf_fetch_cnt, 32'h0);
    check("perf_rst_stall", perf_stall_cnt, 32'h0);
    for (int i = 0; i < 11; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    check("perf_fetch", perf_fetch_cnt, 32'd10);
    check("perf_stall", perf_stall_cnt, 32'd4);
`endif

    // Randomized stall/redirect/reset traffic.
    for (int i = 0; i < 3000; i++) begin
      logic s, r, rs;
      logic [31:0] rpc;
      s   = ($urandom_range(0, 99) < 30);
      r   = ($urandom_range(0, 99) < 4);
      rs  = ($urandom_range(0, 999) < 5);
      rpc = $urandom;
      step(s, r, rpc, rs);
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    check("progress", {31'b0, (n_loads > 1000)}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
